// File: rtl/fmap_rd_addr_gen.sv
// fmap_rd_addr_gen
// Read-side address generator for a stored convolution output feature map.
// Walks every KxK window of each channel-group plane (base g*PLANE_WORDS,
// row-major, four channels per word) and issues one word address per tap over
// a valid/ready handshake. Loop order, innermost first: kx, ky, g, ox, oy.
//
// Optional feature: define FMAP_RD_PAD_EN for same-padding with P=(K-1)/2.
// Out-of-plane taps then present rd_pad=1 with rd_addr=0 and still consume a
// handshake. With the macro undefined only valid windows are walked and
// rd_pad is tied low.
//
// Addresses are built from incremental base registers (plane base, window row
// base, tap row base), so no run-time multiplier is needed. All address math
// wraps modulo 2^ADDR_W.

module fmap_rd_addr_gen #(
    parameter int ROWS        = 14,
    parameter int COLS        = 14,
    parameter int K           = 5,
    parameter int CH_GROUPS   = 1,
    parameter int PLANE_WORDS = 196,
    parameter int ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_pad,
    output logic              win_last,
    output logic              busy,
    output logic              done
);

`ifdef FMAP_RD_PAD_EN
    // Window origin runs over the whole plane; taps are offset by -P.
    localparam int OFF  = (K - 1) / 2;
    localparam int OX_N = COLS;
    localparam int OY_N = ROWS;
`else
    // Only windows that fit entirely inside the plane.
    localparam int OFF  = 0;
    localparam int OX_N = COLS - K + 1;
    localparam int OY_N = ROWS - K + 1;
`endif

    // Counter width must hold oy+ky and ox+kx (up to ROWS+K / COLS+K).
    localparam int CNT_W = $clog2(ROWS + COLS + K + 1);
    localparam int G_W   = (CH_GROUPS > 1) ? $clog2(CH_GROUPS) : 1;

    localparam logic [CNT_W-1:0]  K_LAST   = CNT_W'(K - 1);
    localparam logic [CNT_W-1:0]  OX_LAST  = CNT_W'(OX_N - 1);
    localparam logic [CNT_W-1:0]  OY_LAST  = CNT_W'(OY_N - 1);
    localparam logic [G_W-1:0]    G_LAST   = G_W'(CH_GROUPS - 1);
    localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] PW_A     = ADDR_W'(PLANE_WORDS);
    // Row/column base registers track the unshifted (oy+ky, ox+kx) position;
    // this constant removes the -P shift of the tap origin in one subtract.
    localparam logic [ADDR_W-1:0] ORIGIN_A = ADDR_W'(OFF * COLS + OFF);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0]  kx_q, kx_d;
    logic [CNT_W-1:0]  ky_q, ky_d;
    logic [CNT_W-1:0]  ox_q, ox_d;
    logic [CNT_W-1:0]  oy_q, oy_d;
    logic [G_W-1:0]    g_q, g_d;
    logic [ADDR_W-1:0] plane_base_q, plane_base_d;   // g*PLANE_WORDS
    logic [ADDR_W-1:0] win_row_q, win_row_d;         // oy*COLS
    logic [ADDR_W-1:0] tap_row_q, tap_row_d;         // (oy+ky)*COLS

    logic              xfer;
    logic              kx_wrap, ky_wrap, g_wrap, ox_wrap, oy_wrap;
    logic              last_tap;
    logic              tap_pad;
    logic [ADDR_W-1:0] tap_addr;

    // Wrap decodes and handshake qualifier.
    always_comb begin
        kx_wrap  = (kx_q == K_LAST);
        ky_wrap  = (ky_q == K_LAST);
        g_wrap   = (g_q == G_LAST);
        ox_wrap  = (ox_q == OX_LAST);
        oy_wrap  = (oy_q == OY_LAST);
        last_tap = kx_wrap && ky_wrap && g_wrap && ox_wrap && oy_wrap;
        xfer     = (state_q == S_RUN) && rd_ready;
    end

    // Tap address and padding decode from the current counters.
    always_comb begin
        tap_addr = plane_base_q + tap_row_q + ADDR_W'(ox_q) + ADDR_W'(kx_q) - ORIGIN_A;
`ifdef FMAP_RD_PAD_EN
        tap_pad  = ((oy_q + ky_q) < CNT_W'(OFF))        ||
                   ((oy_q + ky_q) >= CNT_W'(ROWS + OFF)) ||
                   ((ox_q + kx_q) < CNT_W'(OFF))        ||
                   ((ox_q + kx_q) >= CNT_W'(COLS + OFF));
`else
        tap_pad  = 1'b0;
`endif
    end

    // FSM state register.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; combinational blocks use blocking (=).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state logic.
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (xfer && last_tap) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs; address lanes are forced to zero outside RUN.
    always_comb begin
        busy     = (state_q == S_RUN);
        rd_valid = (state_q == S_RUN);
        done     = (state_q == S_DONE);
        rd_pad   = rd_valid && tap_pad;
        rd_addr  = (rd_valid && !tap_pad) ? tap_addr : '0;
        win_last = rd_valid && kx_wrap && ky_wrap && g_wrap;
    end

    // Nested loop counters and base registers; advance only on a transfer.
    // The final transfer wraps everything back to zero, ready for the next pass.
    always_comb begin
        kx_d         = kx_q;
        ky_d         = ky_q;
        g_d          = g_q;
        ox_d         = ox_q;
        oy_d         = oy_q;
        plane_base_d = plane_base_q;
        win_row_d    = win_row_q;
        tap_row_d    = tap_row_q;
        if (xfer) begin
            if (!kx_wrap) begin
                kx_d = kx_q + 1'b1;
            end else begin
                kx_d = '0;
                if (!ky_wrap) begin
                    ky_d      = ky_q + 1'b1;
                    tap_row_d = tap_row_q + COLS_A;
                end else begin
                    ky_d      = '0;
                    tap_row_d = win_row_q;
                    if (!g_wrap) begin
                        g_d          = g_q + 1'b1;
                        plane_base_d = plane_base_q + PW_A;
                    end else begin
                        g_d          = '0;
                        plane_base_d = '0;
                        if (!ox_wrap) begin
                            ox_d = ox_q + 1'b1;
                        end else begin
                            ox_d = '0;
                            if (!oy_wrap) begin
                                oy_d      = oy_q + 1'b1;
                                win_row_d = win_row_q + COLS_A;
                                tap_row_d = win_row_q + COLS_A;
                            end else begin
                                oy_d      = '0;
                                win_row_d = '0;
                                tap_row_d = '0;
                            end
                        end
                    end
                end
            end
        end
    end

    // Counter and base register update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kx_q         <= '0;
            ky_q         <= '0;
            g_q          <= '0;
            ox_q         <= '0;
            oy_q         <= '0;
            plane_base_q <= '0;
            win_row_q    <= '0;
            tap_row_q    <= '0;
        end else begin
            kx_q         <= kx_d;
            ky_q         <= ky_d;
            g_q          <= g_d;
            ox_q         <= ox_d;
            oy_q         <= oy_d;
            plane_base_q <= plane_base_d;
            win_row_q    <= win_row_d;
            tap_row_q    <= tap_row_d;
        end
    end

endmodule

// File: tb/tb_fmap_rd_addr_gen.sv
// tb_fmap_rd_addr_gen
// Directed bench for fmap_rd_addr_gen. dut1 uses default parameters, dut2 uses
// CH_GROUPS=2. Expected tap sequences come from a straightforward nested-loop
// model written with plain multiplies; directed hand values cover the first
// window, the group-1 window, the backpressure hold and the final tap.
// Define FMAP_RD_PAD_EN for both RTL and bench to exercise the padded mode.

`timescale 1ns/1ps

module tb_fmap_rd_addr_gen;

    localparam int ADDR_W = 16;
`ifdef FMAP_RD_PAD_EN
    localparam bit PAD_MODE = 1'b1;
    localparam int PP       = 2;
    localparam int WIN_N    = 14;
`else
    localparam bit PAD_MODE = 1'b0;
    localparam int PP       = 0;
    localparam int WIN_N    = 10;
`endif
    localparam int N1 = WIN_N * WIN_N * 25;
    localparam int N2 = N1 * 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic              start1 = 1'b0, ready1 = 1'b0;
    logic              valid1, pad1, last1, busy1, done1;
    logic [ADDR_W-1:0] addr1;

    logic              start2 = 1'b0, ready2 = 1'b0;
    logic              valid2, pad2, last2, busy2, done2;
    logic [ADDR_W-1:0] addr2;

    int n_asserts = 0;
    int n_fail    = 0;

    // Expected sequences: index 0 for dut1, index 1 for dut2.
    int ea [2][N2];
    bit ep [2][N2];
    bit el [2][N2];

    // Hand-computed first window of plane 0 (unpadded).
    int first25 [25] = '{0, 1, 2, 3, 4, 14, 15, 16, 17, 18, 28, 29, 30, 31, 32,
                         42, 43, 44, 45, 46, 56, 57, 58, 59, 60};

    fmap_rd_addr_gen #(.CH_GROUPS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .rd_ready(ready1),
        .rd_valid(valid1), .rd_addr(addr1), .rd_pad(pad1),
        .win_last(last1), .busy(busy1), .done(done1)
    );

    fmap_rd_addr_gen #(.CH_GROUPS(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .rd_ready(ready2),
        .rd_valid(valid2), .rd_addr(addr2), .rd_pad(pad2),
        .win_last(last2), .busy(busy2), .done(done2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int idx,
                         input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s[%0d]: observed %0d expected %0d", tag, idx, obs, exp);
        end
    endtask

    task automatic build(input int sel, input int groups);
        int i = 0;
        for (int oy = 0; oy < WIN_N; oy++)
            for (int ox = 0; ox < WIN_N; ox++)
                for (int g = 0; g < groups; g++)
                    for (int ky = 0; ky < 5; ky++)
                        for (int kx = 0; kx < 5; kx++) begin
                            int r = oy + ky - PP;
                            int c = ox + kx - PP;
                            if (r < 0 || r >= 14 || c < 0 || c >= 14) begin
                                ep[sel][i] = 1'b1;
                                ea[sel][i] = 0;
                            end else begin
                                ep[sel][i] = 1'b0;
                                ea[sel][i] = (g * 196 + r * 14 + c) % 65536;
                            end
                            el[sel][i] = (g == groups - 1) && (ky == 4) && (kx == 4);
                            i++;
                        end
    endtask

    task automatic check_idle1(input string tag);
        check({tag, "_valid"}, 0, valid1, 0);
        check({tag, "_busy"},  0, busy1,  0);
        check({tag, "_addr"},  0, addr1,  0);
        check({tag, "_pad"},   0, pad1,   0);
        check({tag, "_last"},  0, last1,  0);
        check({tag, "_done"},  0, done1,  0);
    endtask

    // One pass on dut1. bp: hold rd_ready low 3 cycles at index 7.
    // pulse: pulse start mid-pass. abort_at: return early at that index.
    task automatic run1(input bit bp, input bit pulse, input int abort_at);
        int idx  = 0;
        int cyc  = 0;
        int hold = 0;
        start1 = 1'b1;
        ready1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        while (idx < N1 && cyc < N1 + 64) begin
            if (idx == abort_at) return;
            check("p1_valid", idx, valid1, 1);
            check("p1_addr",  idx, addr1,  ea[0][idx]);
            check("p1_pad",   idx, pad1,   ep[0][idx]);
            check("p1_last",  idx, last1,  el[0][idx]);
            if (!PAD_MODE) begin
                if (idx < 25)      check("p1_first25", idx, addr1, first25[idx]);
                if (idx == 24)     check("p1_wlast25", idx, last1, 1);
                if (idx == 25)     check("p1_addr26",  idx, addr1, 1);
                if (idx == N1 - 1) check("p1_final",   idx, addr1, 195);
                if (idx == N1 - 1) check("p1_final_wl", idx, last1, 1);
                if (bp && idx == 7) check("bp_hold", hold, addr1, 16);
                if (bp && idx == 8) check("bp_next", idx, addr1, 17);
            end else begin
                if (idx < 12)            check("pad_w0", idx, pad1, 1);
                if (idx == 12)           check("pad_w0_ctr_pad", idx, pad1, 0);
                if (idx == 12)           check("pad_w0_ctr_addr", idx, addr1, 0);
                if (idx == N1 - 25 + 12) check("pad_wl_ctr_addr", idx, addr1, 195);
                if (idx == N1 - 1)       check("pad_wl_end_pad", idx, pad1, 1);
            end
            start1 = pulse && (idx == 100);
            if (bp && idx == 7 && hold < 3) begin
                ready1 = 1'b0;
                hold++;
            end else begin
                ready1 = 1'b1;
            end
            if (ready1) idx++;
            @(negedge clk);
            cyc++;
        end
        start1 = 1'b0;
        ready1 = 1'b1;
        check("p1_len", abort_at, idx, N1);
        if (bp) check("bp_cycles", 0, cyc, N1 + 3);
    endtask

    initial begin
        build(0, 1);
        build(1, 2);

        // Reset state.
        @(negedge clk);
        check_idle1("rst");
        check("rst2_valid", 0, valid2, 0);
        check("rst2_done",  0, done2,  0);
        rst = 1'b0;
        ready1 = 1'b1;          // ready while idle must have no effect
        @(negedge clk);
        @(negedge clk);
        check_idle1("idle");

        // Full-throughput pass with a start pulse during RUN.
        run1(1'b0, 1'b1, -1);
        check("done_valid", 0, valid1, 0);
        check("done_busy",  0, busy1,  0);
        check("done_pulse", 0, done1,  1);
        start1 = 1'b1;          // start during DONE is ignored
        @(negedge clk);
        start1 = 1'b0;
        check("after_done_pulse", 0, done1, 0);
        check("after_done_busy",  0, busy1, 0);
        @(negedge clk);
        check("still_idle_busy",  0, busy1,  0);
        check("still_idle_valid", 0, valid1, 0);

        // Backpressure pass.
        run1(1'b1, 1'b0, -1);
        check("bp_done", 0, done1, 1);
        @(negedge clk);
        @(negedge clk);

        // Reset in the middle of a pass.
        run1(1'b0, 1'b0, 1000);
        #2 rst = 1'b1;
        #1;
        check_idle1("midrst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle1("post_rst");
        run1(1'b0, 1'b0, -1);
        check("rerun_done", 0, done1, 1);

        // Two channel groups on dut2.
        begin
            int idx = 0;
            int cyc = 0;
            start2 = 1'b1;
            ready2 = 1'b1;
            @(negedge clk);
            start2 = 1'b0;
            while (idx < N2 && cyc < N2 + 64) begin
                check("p2_valid", idx, valid2, 1);
                check("p2_addr",  idx, addr2,  ea[1][idx]);
                check("p2_pad",   idx, pad2,   ep[1][idx]);
                check("p2_last",  idx, last2,  el[1][idx]);
                if (!PAD_MODE && idx >= 25 && idx < 50)
                    check("p2_g1", idx, addr2, first25[idx - 25] + 196);
                if (!PAD_MODE && idx < 50)
                    check("p2_wlast", idx, last2, (idx == 49) ? 1 : 0);
                idx++;
                @(negedge clk);
                cyc++;
            end
            check("p2_len",  0, idx, N2);
            check("p2_done", 0, done2, 1);
            check("p2_busy", 0, busy2, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
